// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared encodings, widths and payload layout for pipe_stage_reg
//
// Contents:
//   STOP / NO_STOP        stall-vector bit encodings
//   *_W_DEF               default payload, scratch and stall-vector widths
//   *_OFF / *_W           bit offsets and widths of fields inside the stage payload
//   action_t              one-hot per-cycle action of the stage register
package pipe_stage_reg_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int PAYLOAD_W_DEF = 160;
  localparam int SCRATCH_W_DEF = 66;
  localparam int STALL_W_DEF   = 6;

  // Payload layout, LSB first. The register forwards the payload as an opaque
  // vector; these offsets let neighbouring stages pack and unpack it consistently.
  localparam int WDATA_OFF      = 0;
  localparam int WDATA_W        = 32;
  localparam int WD_OFF         = WDATA_OFF + WDATA_W;
  localparam int WD_W           = 5;
  localparam int WREG_OFF       = WD_OFF + WD_W;
  localparam int WHILO_OFF      = WREG_OFF + 1;
  localparam int HI_OFF         = WHILO_OFF + 1;
  localparam int HI_W           = 32;
  localparam int LO_OFF         = HI_OFF + HI_W;
  localparam int LO_W           = 32;
  localparam int CP0_WE_OFF     = LO_OFF + LO_W;
  localparam int CP0_WADDR_OFF  = CP0_WE_OFF + 1;
  localparam int CP0_WADDR_W    = 5;
  localparam int EXCEPT_OFF     = CP0_WADDR_OFF + CP0_WADDR_W;
  localparam int EXCEPT_W       = 17;
  localparam int INST_ADDR_OFF  = EXCEPT_OFF + EXCEPT_W;
  localparam int INST_ADDR_W    = 32;
  localparam int DELAYSLOT_OFF  = INST_ADDR_OFF + INST_ADDR_W;
  localparam int PAYLOAD_USED_W = DELAYSLOT_OFF + 1;

  // Exactly one action per cycle; priority is resolved before encoding.
  typedef enum logic [4:0] {
    ACT_RESET   = 5'b00001,
    ACT_BUBBLE  = 5'b00010,
    ACT_FLUSH   = 5'b00100,
    ACT_ADVANCE = 5'b01000,
    ACT_HOLD    = 5'b10000
  } action_t;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// rtl/pipe_stage_reg_sat_counter.sv - saturating up-counter with synchronous clear
//
// Ports:
//   clk    in   clock, rising edge
//   inc    in   add one this cycle (ignored once count is all-ones)
//   clr    in   force count to zero this cycle; wins over inc
//   count  out  registered count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with stall, bubble, flush and statistics
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous reset, active low
//   stall        in   per-stage stall vector, STOP = stage must not advance
//   flush        in   exception flush, discards stage contents
//   in_valid     in   upstream holds a real instruction
//   in_payload   in   upstream payload
//   scratch_i    in   multicycle scratch from the upstream unit
//   out_valid    out  registered valid
//   out_payload  out  registered payload
//   scratch_o    out  registered scratch, fed back upstream
//   bubble_cnt   out  saturating count of inserted bubbles
//   flush_cnt    out  saturating count of flushes taking effect
//   hold_run     out  length of the current consecutive hold run
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int SCRATCH_W = SCRATCH_W_DEF,
  parameter int STALL_W   = STALL_W_DEF,
  parameter int STAGE     = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [SCRATCH_W-1:0] scratch_i,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [SCRATCH_W-1:0] scratch_o,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic [CNT_W-1:0]     hold_run
);

  if (STAGE < 0 || STAGE > STALL_W - 1) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE out of range 0..STALL_W-1");
  end

  logic    stop_here;
  logic    stop_next;
  action_t action;

  assign stop_here = (stall[STAGE] == STOP);

  // The last stage has no downstream stall bit, so it can never hold;
  // any stop request turns into a bubble.
  if (STAGE < STALL_W - 1) begin : g_has_next
    assign stop_next = (stall[STAGE+1] == STOP);
  end else begin : g_no_next
    assign stop_next = NO_STOP;
  end

  // Stall bits of unrelated stages are intentionally ignored.
  logic unused_stall;
  assign unused_stall = ^stall;

  // Bubble is checked before flush so a stage stopping while downstream
  // drains keeps the upstream multicycle scratch even during a flush.
  always_comb begin
    action = ACT_HOLD;
    if (!rst) begin
      action = ACT_RESET;
    end else if (stop_here && !stop_next) begin
      action = ACT_BUBBLE;
    end else if (flush) begin
      action = ACT_FLUSH;
    end else if (!stop_here) begin
      action = ACT_ADVANCE;
    end else begin
      action = ACT_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    case (action)
      ACT_RESET, ACT_FLUSH: begin
        out_valid   <= 1'b0;
        out_payload <= '0;
        scratch_o   <= '0;
      end
      ACT_BUBBLE: begin
        out_valid   <= 1'b0;
        out_payload <= '0;
        scratch_o   <= scratch_i;
      end
      ACT_ADVANCE: begin
        // Payload is loaded even when in_valid is low; consumers qualify with out_valid.
        out_valid   <= in_valid;
        out_payload <= in_payload;
        scratch_o   <= '0;
      end
      default: begin
        out_valid   <= out_valid;
        out_payload <= out_payload;
        scratch_o   <= scratch_o;
      end
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .inc   (action == ACT_BUBBLE),
    .clr   (action == ACT_RESET),
    .count (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .inc   (action == ACT_FLUSH),
    .clr   (action == ACT_RESET),
    .count (flush_cnt)
  );

  // Any non-hold cycle, reset included, ends the current run.
  sat_counter #(.CNT_W(CNT_W)) u_hold_run (
    .clk   (clk),
    .inc   (action == ACT_HOLD),
    .clr   (action != ACT_HOLD),
    .count (hold_run)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed table-driven bench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int PW = 160;
  localparam int SW = 66;
  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [TW-1:0] stall;
  logic          flush;
  logic          in_valid;
  logic [PW-1:0] in_payload;
  logic [SW-1:0] scratch_i;

  logic          a_valid, s_valid, l_valid;
  logic [PW-1:0] a_payload, s_payload, l_payload;
  logic [SW-1:0] a_scratch, s_scratch, l_scratch;
  logic [15:0]   a_bub, a_flu, a_hold, l_bub, l_flu, l_hold;
  logic [3:0]    s_bub, s_flu, s_hold;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_payload(in_payload), .scratch_i(scratch_i),
    .out_valid(a_valid), .out_payload(a_payload), .scratch_o(a_scratch),
    .bubble_cnt(a_bub), .flush_cnt(a_flu), .hold_run(a_hold)
  );

  pipe_stage_reg #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_payload(in_payload), .scratch_i(scratch_i),
    .out_valid(s_valid), .out_payload(s_payload), .scratch_o(s_scratch),
    .bubble_cnt(s_bub), .flush_cnt(s_flu), .hold_run(s_hold)
  );

  pipe_stage_reg #(.STAGE(5)) dut_last (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_payload(in_payload), .scratch_i(scratch_i),
    .out_valid(l_valid), .out_payload(l_payload), .scratch_o(l_scratch),
    .bubble_cnt(l_bub), .flush_cnt(l_flu), .hold_run(l_hold)
  );

  typedef struct {
    logic          rst;
    logic [TW-1:0] stall;
    logic          flush;
    logic          in_valid;
    logic [PW-1:0] payload;
    logic [SW-1:0] scratch;
    logic          e_valid;
    logic [PW-1:0] e_payload;
    logic [SW-1:0] e_scratch;
    logic [15:0]   e_bub;
    logic [15:0]   e_flu;
    logic [15:0]   e_hold;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic vec_t mk(logic r, logic [TW-1:0] st, logic fl, logic iv,
                              logic [PW-1:0] p, logic [SW-1:0] sc,
                              logic ev, logic [PW-1:0] ep, logic [SW-1:0] es,
                              logic [15:0] eb, logic [15:0] ef, logic [15:0] eh);
    vec_t v;
    v.rst = r; v.stall = st; v.flush = fl; v.in_valid = iv; v.payload = p; v.scratch = sc;
    v.e_valid = ev; v.e_payload = ep; v.e_scratch = es;
    v.e_bub = eb; v.e_flu = ef; v.e_hold = eh;
    return v;
  endfunction

  task automatic chk(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(logic r, logic [TW-1:0] st, logic fl, logic iv,
                       logic [PW-1:0] p, logic [SW-1:0] sc);
    @(negedge clk);
    rst = r; stall = st; flush = fl; in_valid = iv; in_payload = p; scratch_i = sc;
    @(posedge clk);
    #1;
  endtask

  localparam logic [TW-1:0] RUN  = 6'b000000;
  localparam logic [TW-1:0] BUB  = 6'b001000;
  localparam logic [TW-1:0] HOLD = 6'b011000;
  localparam logic [SW-1:0] S1   = 66'h2_DEADBEEF_00000001;

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; in_valid = 1'b0; in_payload = '0; scratch_i = '0;

    //        rst stall flush iv payload    scratch_i  | valid payload  scratch bub flu hold
    vecs.push_back(mk(0, HOLD, 1, 1, 'h99,   'h7,   0, 'h0,    'h0, 0, 0, 0));
    vecs.push_back(mk(1, RUN,  0, 1, 'hA5,   'h123, 1, 'hA5,   'h0, 0, 0, 0));
    vecs.push_back(mk(1, BUB,  0, 1, 'hAA,   S1,    0, 'h0,    S1,  1, 0, 0));
    vecs.push_back(mk(1, RUN,  0, 1, 'h1234, 'h0,   1, 'h1234, 'h0, 1, 0, 0));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk(1, HOLD, 0, 1, 'hFFFF, 'h3, 1, 'h1234, 'h0, 1, 0, 16'(i)));
    vecs.push_back(mk(1, RUN,  0, 0, 'h77,   'h0,   0, 'h77,   'h0, 1, 0, 0));
    vecs.push_back(mk(1, BUB,  1, 1, 'h66,   'h5,   0, 'h0,    'h5, 2, 0, 0));
    vecs.push_back(mk(1, RUN,  0, 1, 'hBEEF, 'h0,   1, 'hBEEF, 'h0, 2, 0, 0));
    vecs.push_back(mk(1, BUB,  0, 1, 'h11,   'h9,   0, 'h0,    'h9, 3, 0, 0));
    vecs.push_back(mk(1, HOLD, 0, 1, 'h22,   'hAA,  0, 'h0,    'h9, 3, 0, 1));
    vecs.push_back(mk(1, HOLD, 1, 1, 'h33,   'hAA,  0, 'h0,    'h0, 3, 1, 0));
    vecs.push_back(mk(1, RUN,  1, 1, 'h55,   'h0,   0, 'h0,    'h0, 3, 2, 0));
    vecs.push_back(mk(1, RUN,  0, 1, 'h1234, 'h0,   1, 'h1234, 'h0, 3, 2, 0));
    vecs.push_back(mk(1, HOLD, 0, 1, 'h44,   'h0,   1, 'h1234, 'h0, 3, 2, 1));
    vecs.push_back(mk(1, HOLD, 0, 1, 'h44,   'h0,   1, 'h1234, 'h0, 3, 2, 2));
    vecs.push_back(mk(0, HOLD, 0, 1, 'h44,   'h8,   0, 'h0,    'h0, 0, 0, 0));
    vecs.push_back(mk(1, HOLD, 0, 1, 'h45,   'h8,   0, 'h0,    'h0, 0, 0, 1));
    vecs.push_back(mk(1, 6'b010000, 0, 1, 'hC3, 'h8, 1, 'hC3,  'h0, 0, 0, 0));
    vecs.push_back(mk(1, 6'b100111, 0, 1, 'h3C, 'h8, 1, 'h3C,  'h0, 0, 0, 0));

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].stall, vecs[k].flush, vecs[k].in_valid,
            vecs[k].payload, vecs[k].scratch);
      chk($sformatf("v%0d out_valid", k),   PW'(a_valid),   PW'(vecs[k].e_valid));
      chk($sformatf("v%0d out_payload", k), a_payload,      vecs[k].e_payload);
      chk($sformatf("v%0d scratch_o", k),   PW'(a_scratch), PW'(vecs[k].e_scratch));
      chk($sformatf("v%0d bubble_cnt", k),  PW'(a_bub),     PW'(vecs[k].e_bub));
      chk($sformatf("v%0d flush_cnt", k),   PW'(a_flu),     PW'(vecs[k].e_flu));
      chk($sformatf("v%0d hold_run", k),    PW'(a_hold),    PW'(vecs[k].e_hold));
    end

    // Saturation of a 4-bit bubble counter over 20 consecutive bubbles.
    drive(0, RUN, 0, 0, '0, '0);
    chk("sat reset bubble_cnt", PW'(s_bub), PW'(0));
    for (int i = 1; i <= 20; i++) begin
      drive(1, BUB, 0, 1, PW'(i), SW'(i));
      if (i == 14) chk("sat bubble_cnt@14", PW'(s_bub), PW'(14));
      if (i == 15) chk("sat bubble_cnt@15", PW'(s_bub), PW'(15));
    end
    chk("sat bubble_cnt@20", PW'(s_bub), PW'(15));
    chk("sat scratch_o@20", PW'(s_scratch), PW'(20));
    chk("last stage advance while bit3 stalls", l_payload, PW'(20));

    // Last stage: any stop request is a bubble, never a hold.
    for (int i = 1; i <= 3; i++) drive(1, 6'b100000, 0, 1, 'hD0, SW'(3));
    chk("last bubble_cnt", PW'(l_bub), PW'(3));
    chk("last out_valid", PW'(l_valid), PW'(0));
    chk("last scratch_o", PW'(l_scratch), PW'(3));
    chk("default advances when only bit5 set", a_payload, PW'('hD0));
    drive(1, 6'b110000, 1, 1, 'hD1, SW'(4));
    chk("last bubble over flush bubble_cnt", PW'(l_bub), PW'(4));
    chk("last hold_run stays 0", PW'(l_hold), PW'(0));
    chk("last flush_cnt unchanged", PW'(l_flu), PW'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
